keypad_scanner: RTL and testbench

- Drives the row lines of the calculator's 4x4 matrix keypad and reads the column lines back.
- Debounces key presses and releases internally.
- Emits one registered key code with a single-cycle valid strobe per press.
- Replaces the per-button debouncers on the input side; feeds the calculator's key decoder directly.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/col_sync.sv | 32 +++
 rtl/keypad_scanner.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key encoding for the matrix keypad scanner
//
// Purpose : matrix geometry, key code type, scanner FSM states and the
//           row/column to key code encoder (lowest column wins).
// Ports   : none (package).
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } scan_state_t;

  // pat_n is active-low; walking downwards leaves the lowest low column in col.
  function automatic key_code_t encode_key(input logic [1:0] row, input logic [COLS-1:0] pat_n);
    logic [1:0] col;
    col = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!pat_n[c]) col = c[1:0];
    end
    return {row, col};
  endfunction

endpackage

// File: rtl/col_sync.sv
// rtl/col_sync.sv - two-flop synchronizer for asynchronous active-low inputs
//
// Purpose : brings the keypad column lines into the clk domain.
// Ports   : clk   - system clock
//           rst   - synchronous active-high reset, outputs go to all-ones (idle)
//           i_d   - asynchronous input bus
//           o_q   - synchronized bus
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Purpose : walks one low row at a time, debounces the column pattern seen on
//           that row and emits one key code with a single-cycle strobe per press.
// Ports   : clk       - system clock
//           rst       - synchronous active-high reset
//           col_n     - raw active-low column inputs (asynchronous)
//           row_n     - active-low row drives, exactly one low
//           key_code  - accepted key, row*4+col, held until the next accept
//           key_valid - one-cycle strobe when key_code is (re)issued
//           key_held  - high while the accepted key is still pressed
// Options : KEYPAD_REPEAT_EN - auto-repeat strobes while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output key_code_t key_code,
  output logic      key_valid,
  output logic      key_held
);

  localparam int MAX_A   = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int SW      = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [3:0]    w_cols;
  scan_state_t   r_state, w_state_nx;
  logic [1:0]    r_row, w_row_nx;
  logic [SW-1:0] r_settle, w_settle_nx, w_settle_inc;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [3:0]    r_pat, w_pat_nx;
  key_code_t     r_key_code, w_code_nx;
  logic          r_key_valid, w_valid_nx;
  logic          r_key_held, w_held_nx;
  logic          w_accept, w_release, w_repeat;

  col_sync #(.WIDTH(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .i_d (col_n),
    .o_q (w_cols)
  );

  // Saturating increments: the counters stop at all-ones rather than wrap.
  assign w_settle_inc = (r_settle == '1) ? r_settle : r_settle + 1'b1;
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_row       <= 2'd0;
      r_settle    <= '0;
      r_cnt       <= '0;
      r_pat       <= 4'hF;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_row       <= w_row_nx;
      r_settle    <= w_settle_nx;
      r_cnt       <= w_cnt_nx;
      r_pat       <= w_pat_nx;
      r_key_code  <= w_code_nx;
      r_key_valid <= w_valid_nx;
      r_key_held  <= w_held_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_row_nx    = r_row;
    w_settle_nx = r_settle;
    w_cnt_nx    = r_cnt;
    w_pat_nx    = r_pat;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_settle == SETTLE_LAST) begin
          w_settle_nx = '0;
          if (w_cols != 4'hF) begin
            w_pat_nx   = w_cols;
            w_cnt_nx   = '0;
            w_state_nx = DEBOUNCE;
          end else begin
            w_row_nx = r_row + 2'd1;
          end
        end else begin
          w_settle_nx = w_settle_inc;
        end
      end
      DEBOUNCE: begin
        if (w_cols == r_pat) begin
          if (r_cnt == DB_LAST) begin
            w_accept   = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = HOLD;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end else begin
          w_state_nx  = SCAN;
          w_row_nx    = r_row + 2'd1;
          w_cnt_nx    = '0;
          w_settle_nx = '0;
        end
      end
      HOLD: begin
        // Only the all-high pattern matters here; extra keys in the row are ignored.
        if (w_cols == 4'hF) begin
          if (r_cnt == DB_LAST) begin
            w_release   = 1'b1;
            w_state_nx  = SCAN;
            w_row_nx    = r_row + 2'd1;
            w_cnt_nx    = '0;
            w_settle_nx = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end else begin
          w_cnt_nx = '0;
        end
      end
      default: begin
        w_state_nx  = SCAN;
        w_cnt_nx    = '0;
        w_settle_nx = '0;
      end
    endcase
  end

  always_comb begin
    row_n      = ~(4'b0001 << r_row);
    w_code_nx  = r_key_code;
    w_valid_nx = 1'b0;
    w_held_nx  = r_key_held;
    if (w_accept) begin
      w_code_nx  = encode_key(r_row, r_pat);
      w_valid_nx = 1'b1;
      w_held_nx  = 1'b1;
    end
    if (w_repeat) w_valid_nx = 1'b1;
    if (w_release) w_held_nx = 1'b0;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] r_rep;
  logic          r_rep_armed;
  logic          w_rep_hit;

  // r_rep counts pressed HOLD cycles; the first strobe waits the long delay,
  // later ones (r_rep_armed) the shorter period.
  assign w_rep_hit = (r_state == HOLD) && (w_cols != 4'hF) &&
                     (r_rep == (r_rep_armed ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk) begin
    if (rst || (r_state != HOLD) || (w_cols == 4'hF)) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_hit) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b1;
    end else if (r_rep != '1) begin
      r_rep <= r_rep + 1'b1;
    end
  end

  assign w_repeat = w_rep_hit;
`else
  assign w_repeat = 1'b0;
`endif

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner against a behavioural keypad model
module tb_keypad_scanner;

  localparam int S  = 4;
  localparam int DB = 8;
  localparam int RD = 40;
  localparam int RP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its column to its row when that row is low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  keypad_scanner #(
    .SETTLE_CYCLES (S),
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic int low_col(input logic [3:0] p);
    for (int c = 0; c < 4; c++) if (!p[c]) return c;
    return 0;
  endfunction

  // What the pins looked like at the last rising edge.
  logic [3:0] col_at_edge = 4'hF;
  logic       rst_at_edge = 1'b1;
  always @(posedge clk) begin
    col_at_edge <= col_n;
    rst_at_edge <= rst;
  end

  // Behavioural model: mode 0 scanning, 1 confirming a press, 2 waiting for release.
  logic [3:0] m_s1, m_s2, m_cols, m_pat, m_code;
  int m_mode, m_row, m_t, m_n, m_since;
  bit m_valid, m_held, m_ok = 0;

  task automatic model_step();
    if (rst_at_edge) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF; m_code = 4'd0;
      m_mode = 0; m_row = 0; m_t = 0; m_n = 0; m_since = 0;
      m_valid = 0; m_held = 0; m_ok = 1;
    end else if (m_ok) begin
      m_cols  = m_s2;
      m_valid = 0;
      case (m_mode)
        0: begin
          if (m_t == S - 1) begin
            m_t = 0;
            if (m_cols != 4'hF) begin m_pat = m_cols; m_n = 0; m_mode = 1; end
            else m_row = (m_row + 1) % 4;
          end else m_t++;
        end
        1: begin
          if (m_cols == m_pat) begin
            m_n++;
            if (m_n == DB) begin
              m_code = 4'(m_row * 4 + low_col(m_pat));
              m_valid = 1; m_held = 1; m_mode = 2; m_n = 0; m_since = 0;
            end
          end else begin
            m_mode = 0; m_row = (m_row + 1) % 4; m_n = 0; m_t = 0;
          end
        end
        default: begin
          if (m_cols == 4'hF) begin
            m_since = 0;
            m_n++;
            if (m_n == DB) begin
              m_held = 0; m_mode = 0; m_row = (m_row + 1) % 4; m_n = 0; m_t = 0;
            end
          end else begin
            m_n = 0;
            m_since++;
`ifdef KEYPAD_REPEAT_EN
            if (m_since >= RD && (m_since - RD) % RP == 0) m_valid = 1;
`endif
          end
        end
      endcase
      m_s2 = m_s1;
      m_s1 = col_at_edge;
    end
  endtask

  int pulses_t[$];
  int pulses_c[$];

  initial forever begin
    logic [3:0] e_row;
    @(negedge clk);
    cyc++;
    model_step();
    if (m_ok) begin
      e_row = ~(4'b0001 << m_row);
      check("row_n", int'(row_n), int'(e_row));
      check("key_code", int'(key_code), int'(m_code));
      check("key_valid", int'(key_valid), int'(m_valid));
      check("key_held", int'(key_held), int'(m_held));
    end
    if (key_valid === 1'b1) begin
      pulses_t.push_back(cyc);
      pulses_c.push_back(int'(key_code));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // what: 0 key_valid high, 1 key_held high, 2 key_held low
  task automatic wait_cond(input int what, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick(1);
      case (what)
        0: hit = (key_valid === 1'b1);
        1: hit = (key_held === 1'b1);
        default: hit = (key_held === 1'b0);
      endcase
    end
    check(name, int'(hit), 1);
  endtask

  task automatic release_all();
    keys = '0;
    wait_cond(2, 200, "release_wait");
    tick(3);
  endtask

  initial begin
    int n0, t0, i0, k, c2, row, exp_code, start;
    int offs[4];
    offs[0] = 40; offs[1] = 56; offs[2] = 72; offs[3] = 88;

    tick(3);
    check("reset_row_n", int'(row_n), 4'b1110);
    check("reset_key_held", int'(key_held), 0);
    rst = 1'b0;

    // Idle scanning: one row per S cycles, no strobes.
    n0 = pulses_t.size();
    for (int kk = 0; kk < 64; kk++) begin
      logic [3:0] e;
      e = ~(4'b0001 << ((kk / S) % 4));
      check("idle_row", int'(row_n), int'(e));
      tick(1);
    end
    check("idle_no_pulse", pulses_t.size() - n0, 0);

    // Key 9 with three 2-cycle bounces, then release with a 3-cycle bounce.
    n0 = pulses_t.size();
    for (int b = 0; b < 3; b++) begin
      keys[9] = 1'b1; tick(2);
      keys[9] = 1'b0; tick(2);
    end
    keys[9] = 1'b1;
    wait_cond(1, 200, "k9_held_wait");
    tick(20);
    check("k9_pulses", pulses_t.size() - n0, 1);
    check("k9_code", int'(key_code), 9);
    check("k9_held", int'(key_held), 1);
    keys[9] = 1'b0; tick(2);
    keys[9] = 1'b1; tick(3);
    keys[9] = 1'b0;
    start = cyc;
    wait_cond(2, 100, "k9_release_wait");
    check("k9_release_min", int'(cyc - start >= DB), 1);
    check("k9_resume_row3", int'(row_n), 4'b0111);
    tick(5);

    // Two columns of row 1: column 0 wins.
    n0 = pulses_t.size();
    keys[4] = 1'b1; keys[6] = 1'b1;
    wait_cond(0, 200, "k4_valid_wait");
    check("k4_code", int'(key_code), 4);
    tick(20);
    check("k4_pulses", pulses_t.size() - n0, 1);
    release_all();

    // Reset during HOLD of key 15, then re-detection from a clean scan.
    keys[15] = 1'b1;
    wait_cond(1, 200, "k15_held_wait");
    tick(5);
    rst = 1'b1;
    tick(1);
    check("k15_rst_held", int'(key_held), 0);
    check("k15_rst_valid", int'(key_valid), 0);
    check("k15_rst_code", int'(key_code), 0);
    check("k15_rst_row", int'(row_n), 4'b1110);
    rst = 1'b0;
    start = cyc;
    n0 = pulses_t.size();
    wait_cond(0, 200, "k15_valid_wait");
    check("k15_code", int'(key_code), 15);
    check("k15_latency", cyc - start, 3 * S + S + DB);
    release_all();

    // Key 6 held for 100 cycles after acceptance.
    keys[6] = 1'b1;
    wait_cond(0, 200, "k6_valid_wait");
    check("k6_code", int'(key_code), 6);
    i0 = pulses_t.size() - 1;
    t0 = cyc;
    tick(100);
`ifdef KEYPAD_REPEAT_EN
    check("k6_pulses", pulses_t.size() - i0, 5);
    for (int j = 0; j < 4; j++)
      if (i0 + 1 + j < pulses_t.size()) begin
        check("k6_repeat_offset", pulses_t[i0+1+j] - t0, offs[j]);
        check("k6_repeat_code", pulses_c[i0+1+j], 6);
      end
`else
    check("k6_pulses", pulses_t.size() - i0, 1);
`endif
    release_all();

    // Randomized presses with bounces; the model follows every cycle.
    for (int it = 0; it < 10; it++) begin
      k   = $urandom_range(0, 15);
      row = k / 4;
      exp_code = k;
      c2  = -1;
      if ($urandom_range(0, 2) == 0) begin
        c2 = $urandom_range(0, 3);
        if (c2 < k % 4) exp_code = row * 4 + c2;
      end
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        keys[k] = 1'b1; tick($urandom_range(1, 3));
        keys[k] = 1'b0; tick($urandom_range(1, 3));
      end
      keys[k] = 1'b1;
      if (c2 >= 0) keys[row*4+c2] = 1'b1;
      wait_cond(0, 300, "rnd_valid_wait");
      check("rnd_code", int'(key_code), exp_code);
      tick($urandom_range(10, 60));
      keys = '0; tick($urandom_range(1, 5));
      keys[k] = 1'b1; tick($urandom_range(1, 3));
      release_all();
      tick($urandom_range(0, 20));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
